// File: rtl/uart_tx_fifo_drain_if.sv
// Fifo read port plus serial-side status of the UART drain transmitter.
// The master modport is the transmitter; the slave modport is the fifo/observer side.
interface uart_tx_fifo_drain_if #(
  parameter int data_width = 8
);
  logic                  FIFO_EMPTY;
  logic [data_width-1:0] FIFO_RDAT;
  logic                  FIFO_RDAT_EN;
  logic                  FIFO_REN;
  logic                  TXD;
  logic                  BUSY;
  logic                  TX_DONE;

  modport master (
    input  FIFO_EMPTY, FIFO_RDAT, FIFO_RDAT_EN,
    output FIFO_REN, TXD, BUSY, TX_DONE
  );

  modport slave (
    output FIFO_EMPTY, FIFO_RDAT, FIFO_RDAT_EN,
    input  FIFO_REN, TXD, BUSY, TX_DONE
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a TX fifo: pops one character at a time and
// serialises it LSB first with optional parity and 1 or 2 stop bits.
module uart_tx_fifo_drain #(
  parameter int data_width = 8,
  parameter int clk_div    = 104,
  parameter int parity     = 0,
  parameter int stop_bits  = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  uart_tx_fifo_drain_if.master   bus
);
  localparam int BW = $clog2(clk_div);
  localparam int CW = $clog2(data_width + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(clk_div - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(clk_div - 2);
  localparam logic [CW-1:0] BITS_LAST = CW'(data_width);
  localparam logic [CW-1:0] STOP_LAST = CW'(stop_bits - 1);
  localparam logic          ODD       = (parity == 2);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PAR, STOP} state_t;

  state_t                state;
  logic [BW-1:0]         baud_cnt;
  logic [CW-1:0]         bit_cnt;
  logic [data_width-1:0] shreg;
  logic                  par_bit;
  logic                  txd_r;
  logic                  done_r;
  logic                  ren;
  logic                  baud_tc;

  // REN is decoded straight from IDLE so the pop lands in the first idle
  // cycle; this gives the two-cycle stop-to-start turnaround.
  assign ren         = (state == IDLE) && !bus.FIFO_EMPTY && !RESET;
  assign baud_tc     = (baud_cnt == BAUD_LAST);
  assign bus.FIFO_REN = ren;
  assign bus.BUSY    = (state != IDLE) || ren;
  assign bus.TXD     = txd_r;
  assign bus.TX_DONE = done_r;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd_r    <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state inside {START, DATA, PAR, STOP})
        baud_cnt <= baud_tc ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (ren) state <= FETCH;
        end
        FETCH: begin
          // No data strobe means the fifo declined the pop; retry from IDLE.
          if (bus.FIFO_RDAT_EN) begin
            shreg    <= bus.FIFO_RDAT;
            par_bit  <= (^bus.FIFO_RDAT) ^ ODD;
            txd_r    <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (baud_tc) begin
            txd_r   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= CW'(1);
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tc) begin
            if (bit_cnt == BITS_LAST) begin
              bit_cnt <= '0;
              if (parity != 0) begin
                txd_r <= par_bit;
                state <= PAR;
              end else begin
                txd_r <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd_r   <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (baud_tc) begin
            txd_r   <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          // Raise TX_DONE one cycle early so it is high on the final stop cycle.
          if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) done_r <= 1'b1;
          if (baud_tc) begin
            if (bit_cnt == STOP_LAST) state <= IDLE;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
